logic_auth: RTL and testbench
=============================

# logic_auth

Synchronous 4-bit password authentication block. A password is loaded through the setter port and later guesses are compared against it. Each guess produces a one-cycle match or fail pulse, and repeated failures trigger a timed lockout. It sits between the user-input front end and any unlock or enable logic downstream.

## Interface
Parameters:
- MAX_ATTEMPTS, 3: consecutive wrong guesses that trigger lockout; legal range 1–15.
- LOCK_CYCLES, 16: number of clock cycles spent in lockout; legal range 1–255.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: reset, synchronous and active-high.
- set_bits, input, 4: password to store; bit 3 is the first/MSB digit.
- set_valid, input, 1: load strobe for set_bits.
- guess_bits, input, 4: candidate password, same bit order as set_bits.
- guess_valid, input, 1: compare strobe for guess_bits.
- armed, output, 1: high while a password is stored and the block is not locked.
- match, output, 1: one-cycle pulse when a guess equals the stored password.
- fail, output, 1: one-cycle pulse when a guess is wrong.
- locked, output, 1: high while in lockout.
- attempts_left, output, 4: remaining wrong guesses before lockout.

## Operation
States:
- UNSET
  - Guesses are ignored: no match or fail pulse.
  - set_valid loads set_bits, clears the fail counter, and moves to ARMED.
- ARMED
  - set_valid reloads the password and clears the fail counter. Any guess in the same cycle is dropped, so set wins.
  - guess_valid with guess_bits equal to the stored value:
    - match=1 for one cycle;
    - fail counter cleared.
  - guess_valid with a mismatch:
    - fail=1 for one cycle;
    - fail counter incremented.
  - If the counter reaches MAX_ATTEMPTS, go to LOCKED and load the lock timer with LOCK_CYCLES.
- LOCKED
  - set_valid and guess_valid are both ignored.
  - The lock timer decrements every cycle.
  - On the cycle the timer reaches 0, clear the fail counter and return to ARMED. The stored password is kept.
- Derived outputs:
  - attempts_left = MAX_ATTEMPTS − fail counter.
  - attempts_left is 0 in LOCKED and MAX_ATTEMPTS in UNSET.
- Comparison is exact 4-bit equality. The value 0000 is a legal password.
- match and fail are mutually exclusive and never high in the same cycle.

## Timing
- All outputs are registered. Response latency is 1 cycle: a strobe sampled at edge N gives outputs valid after edge N.
- Reset values:
  - State UNSET, stored password 0000.
  - fail counter 0, lock timer 0.
  - armed=0, match=0, fail=0, locked=0, attempts_left=MAX_ATTEMPTS.
- Reset overrides everything, including an active lockout and strobes in the same cycle.
- On the failing guess that triggers lockout:
  - fail pulses in the same cycle that locked rises;
  - armed falls in that cycle.
- Lockout length: locked stays high for exactly LOCK_CYCLES cycles, then armed=1 and attempts_left=MAX_ATTEMPTS.
- A guess_valid arriving on the first ARMED cycle after lockout is evaluated normally.
- Back-to-back guess_valid on consecutive cycles are all evaluated. There is no handshake or backpressure.

## Structure
- Shared package (auth_pkg):
  - state enum {UNSET, ARMED, LOCKED};
  - PW_W=4 constant.
- One sub-module, auth_lock_timer: a loadable down-counter with a done flag, sized $clog2(LOCK_CYCLES+1).
- The top level holds the FSM, the password register, the fail counter (4 bits) and the comparator.

## Test plan
- Reset, then guess_valid with 0000 and no password set → match=0, fail=0, armed=0.
- set 1011, then guess 1011 → armed=1 and match pulses 1 cycle after the guess; attempts_left=3.
- set 0110, guess 0111 twice, then 0110 → two fail pulses, attempts_left goes 2 then 1, then match and attempts_left back to 3.
- set 0001, three wrong guesses:
  - third fail pulses with locked=1;
  - during lock a correct guess and a set 1111 are ignored;
  - after 16 cycles locked=0, armed=1, and guess 0001 gives match.
- ARMED with set_valid=1111 and guess_valid=0000 in the same cycle → no pulse; the next guess 1111 gives match.
- Assert rst mid-lockout → the next cycle is UNSET with all outputs at reset values.

Source files
------------

// File: rtl/auth_pkg.sv
// Shared types and constants for the logic_auth password block.
package auth_pkg;

    localparam int PW_W = 4;

    typedef enum logic [1:0] {
        UNSET  = 2'd0,
        ARMED  = 2'd1,
        LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/auth_lock_timer.sv
// Loadable down-counter for the lockout window; done flags the final locked cycle.
module auth_lock_timer #(
    parameter int LOCK_CYCLES = 16,
    localparam int W = $clog2(LOCK_CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic done
);

    logic [W-1:0] count;

    // Asserted while the count is about to hit zero, so the caller can leave
    // lockout on that same edge and keep locked high for exactly LOCK_CYCLES.
    assign done = (count == W'(1));

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (load)
            count <= W'(LOCK_CYCLES);
        else if (dec && count != '0)
            count <= count - W'(1);
    end

endmodule

// File: rtl/logic_auth.sv
// 4-bit password authentication: stores a password, checks guesses, locks out after repeated failures.
module logic_auth
    import auth_pkg::*;
#(
    parameter int MAX_ATTEMPTS = 3,
    parameter int LOCK_CYCLES  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [PW_W-1:0] set_bits,
    input  logic            set_valid,
    input  logic [PW_W-1:0] guess_bits,
    input  logic            guess_valid,
    output logic            armed,
    output logic            match,
    output logic            fail,
    output logic            locked,
    output logic [3:0]      attempts_left
);

    state_t          state, state_n;
    logic [PW_W-1:0] pw, pw_n;
    logic [3:0]      fail_cnt, fail_cnt_n;
    logic [3:0]      fail_inc;
    logic            match_n, fail_n, armed_n, locked_n;
    logic [3:0]      attempts_n;
    logic            tmr_load, tmr_dec, tmr_done;

    auth_lock_timer #(.LOCK_CYCLES(LOCK_CYCLES)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (tmr_load),
        .dec  (tmr_dec),
        .done (tmr_done)
    );

    assign fail_inc = fail_cnt + 4'd1;

    always_comb begin
        state_n    = state;
        pw_n       = pw;
        fail_cnt_n = fail_cnt;
        match_n    = 1'b0;
        fail_n     = 1'b0;
        tmr_load   = 1'b0;
        tmr_dec    = 1'b0;
        unique case (state)
            UNSET: begin
                if (set_valid) begin
                    pw_n       = set_bits;
                    fail_cnt_n = '0;
                    state_n    = ARMED;
                end
            end
            ARMED: begin
                // A load in the same cycle as a guess drops the guess.
                if (set_valid) begin
                    pw_n       = set_bits;
                    fail_cnt_n = '0;
                end else if (guess_valid) begin
                    if (guess_bits == pw) begin
                        match_n    = 1'b1;
                        fail_cnt_n = '0;
                    end else begin
                        fail_n     = 1'b1;
                        fail_cnt_n = fail_inc;
                        if (fail_inc >= 4'(MAX_ATTEMPTS)) begin
                            state_n  = LOCKED;
                            tmr_load = 1'b1;
                        end
                    end
                end
            end
            LOCKED: begin
                tmr_dec = 1'b1;
                if (tmr_done) begin
                    fail_cnt_n = '0;
                    state_n    = ARMED;
                end
            end
            default: state_n = UNSET;
        endcase

        armed_n    = (state_n == ARMED);
        locked_n   = (state_n == LOCKED);
        attempts_n = locked_n ? 4'd0 : 4'(MAX_ATTEMPTS) - fail_cnt_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= UNSET;
            pw            <= '0;
            fail_cnt      <= '0;
            armed         <= 1'b0;
            match         <= 1'b0;
            fail          <= 1'b0;
            locked        <= 1'b0;
            attempts_left <= 4'(MAX_ATTEMPTS);
        end else begin
            state         <= state_n;
            pw            <= pw_n;
            fail_cnt      <= fail_cnt_n;
            armed         <= armed_n;
            match         <= match_n;
            fail          <= fail_n;
            locked        <= locked_n;
            attempts_left <= attempts_n;
        end
    end

endmodule

// File: tb/tb_logic_auth.sv
// Scoreboard bench for logic_auth: each driven cycle queues its expected outputs, checked after the edge.
module tb_logic_auth;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] set_bits = '0;
    logic       set_valid = 1'b0;
    logic [3:0] guess_bits = '0;
    logic       guess_valid = 1'b0;
    logic       armed, match, fail, locked;
    logic [3:0] attempts_left;

    int n_vec = 0;
    int n_err = 0;

    typedef struct packed {
        logic       m;
        logic       f;
        logic       a;
        logic       l;
        logic [3:0] att;
    } exp_t;

    exp_t sb_q[$];

    logic_auth #(.MAX_ATTEMPTS(3), .LOCK_CYCLES(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .set_bits      (set_bits),
        .set_valid     (set_valid),
        .guess_bits    (guess_bits),
        .guess_valid   (guess_valid),
        .armed         (armed),
        .match         (match),
        .fail          (fail),
        .locked        (locked),
        .attempts_left (attempts_left)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, then check after the edge.
    task automatic cyc(input logic r, input logic sv, input logic [3:0] sb,
                       input logic gv, input logic [3:0] gb,
                       input logic em, input logic ef, input logic ea,
                       input logic el, input logic [3:0] eatt);
        exp_t e;
        rst         = r;
        set_valid   = sv;
        set_bits    = sb;
        guess_valid = gv;
        guess_bits  = gb;
        sb_q.push_back('{m: em, f: ef, a: ea, l: el, att: eatt});
        @(posedge clk);
        #1;
        rst         = 1'b0;
        set_valid   = 1'b0;
        guess_valid = 1'b0;
        if (sb_q.size() == 0) begin
            chk("sb_empty", 8'd1, 8'd0);
        end else begin
            e = sb_q.pop_front();
            chk("match",         {7'd0, match},  {7'd0, e.m});
            chk("fail",          {7'd0, fail},   {7'd0, e.f});
            chk("armed",         {7'd0, armed},  {7'd0, e.a});
            chk("locked",        {7'd0, locked}, {7'd0, e.l});
            chk("attempts_left", {4'd0, attempts_left}, {4'd0, e.att});
        end
    endtask

    initial begin
        @(negedge clk);
        //   rst sv  sb     gv  gb     m  f  a  l  att
        cyc(1, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 4'd3);   // reset
        cyc(0, 0, 4'h0, 1, 4'h0, 0, 0, 0, 0, 4'd3);   // guess while unset ignored
        cyc(0, 1, 4'hB, 0, 4'h0, 0, 0, 1, 0, 4'd3);   // set 1011
        cyc(0, 0, 4'h0, 1, 4'hB, 1, 0, 1, 0, 4'd3);   // correct guess
        cyc(0, 0, 4'h0, 0, 4'h0, 0, 0, 1, 0, 4'd3);   // match is one cycle

        cyc(0, 1, 4'h6, 0, 4'h0, 0, 0, 1, 0, 4'd3);   // set 0110
        cyc(0, 0, 4'h0, 1, 4'h7, 0, 1, 1, 0, 4'd2);
        cyc(0, 0, 4'h0, 1, 4'h7, 0, 1, 1, 0, 4'd1);
        cyc(0, 0, 4'h0, 1, 4'h6, 1, 0, 1, 0, 4'd3);   // match clears counter

        cyc(0, 1, 4'h1, 0, 4'h0, 0, 0, 1, 0, 4'd3);   // set 0001
        cyc(0, 0, 4'h0, 1, 4'h0, 0, 1, 1, 0, 4'd2);
        cyc(0, 0, 4'h0, 1, 4'h2, 0, 1, 1, 0, 4'd1);
        cyc(0, 0, 4'h0, 1, 4'h4, 0, 1, 0, 1, 4'd0);   // third fail enters lockout
        for (int i = 0; i < 15; i++)
            cyc(0, (i == 1), 4'hF, (i == 0), 4'h1, 0, 0, 0, 1, 4'd0);
        cyc(0, 0, 4'h0, 0, 4'h0, 0, 0, 1, 0, 4'd3);   // lockout over after 16 cycles
        cyc(0, 0, 4'h0, 1, 4'h1, 1, 0, 1, 0, 4'd3);   // password kept through lockout

        cyc(0, 1, 4'hF, 1, 4'h0, 0, 0, 1, 0, 4'd3);   // set wins over same-cycle guess
        cyc(0, 0, 4'h0, 1, 4'hF, 1, 0, 1, 0, 4'd3);
        cyc(0, 0, 4'h0, 1, 4'h0, 0, 1, 1, 0, 4'd2);
        cyc(0, 1, 4'hF, 0, 4'h0, 0, 0, 1, 0, 4'd3);   // reload clears counter

        cyc(0, 0, 4'h0, 1, 4'h0, 0, 1, 1, 0, 4'd2);
        cyc(0, 0, 4'h0, 1, 4'h0, 0, 1, 1, 0, 4'd1);
        cyc(0, 0, 4'h0, 1, 4'h0, 0, 1, 0, 1, 4'd0);
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 4'h0, 0, 4'h0, 0, 0, 0, 1, 4'd0);
        cyc(1, 1, 4'hF, 1, 4'hF, 0, 0, 0, 0, 4'd3);   // reset mid-lockout with strobes
        cyc(0, 0, 4'h0, 1, 4'hF, 0, 0, 0, 0, 4'd3);   // back in UNSET
        cyc(0, 1, 4'h0, 0, 4'h0, 0, 0, 1, 0, 4'd3);   // 0000 is a legal password
        cyc(0, 0, 4'h0, 1, 4'h0, 1, 0, 1, 0, 4'd3);

        if (sb_q.size() != 0)
            chk("sb_drain", 8'(sb_q.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
